// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the CPU pipeline slice: MEM-stage FSM encoding,
// default datapath widths and the word-alignment helper.
package cpu_defs_pkg;

  // Default datapath widths
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // MEM-stage states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // True when the byte address is not word aligned
  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for the MEM stage. Built only when MEM_TIMEOUT_EN is
// defined. expired is asserted during the TIMEOUT_CYCLES-th enabled cycle
// after a clear, so an unanswered request is held exactly TIMEOUT_CYCLES cycles.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  // Count enabled cycles since the last clear; stop once expired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns the EX ALU result into a data-memory req/ack
// access (LW/SW) or passes it straight through, and hands a one-cycle
// result to WB. EX is stalled (ex_ready low) whenever the stage is busy.
// Optional feature macro: MEM_TIMEOUT_EN (abandon a request that is not
// acknowledged within TIMEOUT_CYCLES wait cycles and report an error).
module mem_access_stage
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int REG_W          = DEF_REG_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write,
  output logic              wb_error
);

  mem_state_t        state_reg, state_next;

  // Request side: held stable for the whole WAIT phase
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [REG_W-1:0]  rd_reg, rd_next;
  logic              reg_write_reg, reg_write_next;
  logic              flushed_reg, flushed_next;

  // Response side: holds the last result presented to WB
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic [REG_W-1:0]  wb_rd_reg, wb_rd_next;
  logic              wb_reg_write_reg, wb_reg_write_next;
  logic              wb_error_reg, wb_error_next;

  logic accept;
  logic is_mem_op;
  logic misaligned;
  logic timeout_hit;

  assign accept     = ex_valid && (state_reg == ST_IDLE) && !flush;
  assign is_mem_op  = ex_mem_read || ex_mem_write;
  assign misaligned = addr_misaligned(ex_alu_result[1:0]);

`ifdef MEM_TIMEOUT_EN
  logic wait_entry;

  // Counter restarts on every entry into WAIT
  assign wait_entry = accept && is_mem_op && !misaligned;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_entry),
    .enable (state_reg == ST_WAIT),
    .expired(timeout_hit)
  );
`else
  // Without the timeout feature a request waits for its ack indefinitely
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES only shapes timeout builds; referenced here so both
  // builds share one parameter list without an unused-parameter warning
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  // State and datapath registers; reset abandons any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      we_reg           <= 1'b0;
      rd_reg           <= '0;
      reg_write_reg    <= 1'b0;
      flushed_reg      <= 1'b0;
      wb_data_reg      <= '0;
      wb_rd_reg        <= '0;
      wb_reg_write_reg <= 1'b0;
      wb_error_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      we_reg           <= we_next;
      rd_reg           <= rd_next;
      reg_write_reg    <= reg_write_next;
      flushed_reg      <= flushed_next;
      wb_data_reg      <= wb_data_next;
      wb_rd_reg        <= wb_rd_next;
      wb_reg_write_reg <= wb_reg_write_next;
      wb_error_reg     <= wb_error_next;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    we_next           = we_reg;
    rd_next           = rd_reg;
    reg_write_next    = reg_write_reg;
    flushed_next      = flushed_reg;
    wb_data_next      = wb_data_reg;
    wb_rd_next        = wb_rd_reg;
    wb_reg_write_next = wb_reg_write_reg;
    wb_error_next     = wb_error_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_mem_op && !misaligned) begin
            // Aligned load/store: launch the memory request.
            // Read wins when both read and write are flagged.
            state_next     = ST_WAIT;
            addr_next      = ex_alu_result;
            wdata_next     = ex_store_data;
            we_next        = ex_mem_write && !ex_mem_read;
            rd_next        = ex_rd;
            reg_write_next = ex_reg_write;
            flushed_next   = 1'b0;
          end else begin
            // Pass-through op, or a misaligned access reported as an error
            // without touching memory
            state_next        = ST_RESP;
            wb_data_next      = ex_alu_result;
            wb_rd_next        = ex_rd;
            wb_reg_write_next = ex_reg_write && !is_mem_op;
            wb_error_next     = is_mem_op;
          end
        end
      end

      ST_WAIT: begin
        // A flush cannot cancel the bus transfer; remember it so the
        // eventual result is silently dropped
        if (flush) begin
          flushed_next = 1'b1;
        end
        if (dmem_ack) begin
          if (flushed_reg || flush) begin
            state_next = ST_IDLE;
          end else begin
            state_next        = ST_RESP;
            wb_data_next      = we_reg ? addr_reg : dmem_rdata;
            wb_rd_next        = rd_reg;
            wb_reg_write_next = reg_write_reg && !we_reg;
            wb_error_next     = 1'b0;
          end
        end else if (timeout_hit) begin
          if (flushed_reg || flush) begin
            state_next = ST_IDLE;
          end else begin
            state_next        = ST_RESP;
            wb_data_next      = addr_reg;
            wb_rd_next        = rd_reg;
            wb_reg_write_next = 1'b0;
            wb_error_next     = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ex_ready     = (state_reg == ST_IDLE);
  assign dmem_req     = (state_reg == ST_WAIT);
  assign dmem_we      = we_reg;
  assign dmem_addr    = addr_reg;
  assign dmem_wdata   = wdata_reg;
  assign wb_valid     = (state_reg == ST_RESP) && !flush;
  assign wb_data      = wb_data_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_reg_write = wb_reg_write_reg;
  assign wb_error     = wb_error_reg;

endmodule
